// File: rtl/dfi_phy_lite_resp.sv
// Lightweight DFI PHY responder: init handshake, ctrlupd/low-power acks, fixed-latency read return.
// Read valid lags rddata_en by C_TPHY_RDLAT cycles; no backpressure, every enable returns one valid beat.
module dfi_phy_lite_resp #(
    parameter int C_DFI_FREQ_RATIO   = 4,
    parameter int C_DFI_DATAEN_WIDTH = 4,
    parameter int C_DFI_DATA_WIDTH   = 32,
    parameter int C_INIT_CYCLES      = 16,
    parameter int C_TPHY_RDLAT       = 6,
    parameter int C_TCTRLUPD_ACK     = 2,
    parameter int C_TLP_ACK          = 3
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          dfi_init_start,
    output logic                                          dfi_init_complete,
    input  logic                                          dfi_ctrlupd_req,
    output logic                                          dfi_ctrlupd_ack,
    output logic                                          dfi_phyupd_req,
    output logic [1:0]                                    dfi_phyupd_type,
    input  logic                                          dfi_lp_ctrl_req,
    input  logic                                          dfi_lp_data_req,
    output logic                                          dfi_lp_ack,
    input  logic [C_DFI_DATAEN_WIDTH*C_DFI_FREQ_RATIO-1:0] dfi_rddata_en,
    output logic [C_DFI_DATAEN_WIDTH*C_DFI_FREQ_RATIO-1:0] dfi_rddata_valid,
    output logic [C_DFI_DATA_WIDTH*C_DFI_FREQ_RATIO-1:0]   dfi_rddata
);

    localparam int EN_W   = C_DFI_DATAEN_WIDTH * C_DFI_FREQ_RATIO;
    localparam int INIT_W = $clog2(C_INIT_CYCLES + 1);
    localparam int UPD_W  = $clog2(C_TCTRLUPD_ACK + 1);
    localparam int LP_W   = $clog2(C_TLP_ACK + 1);

    // The state register itself costs one cycle, so the counters stop two short of the target delay.
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'((C_INIT_CYCLES > 1) ? C_INIT_CYCLES - 2 : 0);
    localparam logic [UPD_W-1:0]  UPD_LAST  = UPD_W'((C_TCTRLUPD_ACK > 1) ? C_TCTRLUPD_ACK - 2 : 0);
    localparam logic [LP_W-1:0]   LP_LAST   = LP_W'((C_TLP_ACK > 1) ? C_TLP_ACK - 2 : 0);

    typedef enum logic [1:0] {INIT_IDLE, INIT_RUN, INIT_DONE} init_state_t;
    typedef enum logic [1:0] {UPD_IDLE, UPD_WAIT, UPD_ACK} upd_state_t;
    typedef enum logic [1:0] {LP_IDLE, LP_WAIT, LP_ACK} lp_state_t;

    init_state_t       init_state, init_nxt;
    upd_state_t        upd_state, upd_nxt;
    lp_state_t         lp_state, lp_nxt;
    logic [INIT_W-1:0] init_cnt, init_cnt_nxt;
    logic [UPD_W-1:0]  upd_cnt, upd_cnt_nxt;
    logic [LP_W-1:0]   lp_cnt, lp_cnt_nxt;
    logic              init_prev;
    logic              init_rise;
    logic              init_complete;
    logic              lp_req;
    logic              upd_start;
    logic              lp_start;
    logic [31:0]       beat_cnt;
    logic [EN_W-1:0]   rd_dly [C_TPHY_RDLAT];

    assign init_rise     = dfi_init_start & ~init_prev;
    assign init_complete = (init_state == INIT_DONE);
    assign lp_req        = dfi_lp_ctrl_req | dfi_lp_data_req;

    // Ctrlupd wins a simultaneous request; each side waits for the other to be idle.
    assign upd_start = (upd_state == UPD_IDLE) && init_complete && dfi_ctrlupd_req && (lp_state == LP_IDLE);
    assign lp_start  = (lp_state == LP_IDLE) && init_complete && lp_req &&
                       (upd_state == UPD_IDLE) && !upd_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_state <= INIT_IDLE;
            upd_state  <= UPD_IDLE;
            lp_state   <= LP_IDLE;
            init_cnt   <= '0;
            upd_cnt    <= '0;
            lp_cnt     <= '0;
            init_prev  <= 1'b0;
        end else begin
            init_state <= init_nxt;
            upd_state  <= upd_nxt;
            lp_state   <= lp_nxt;
            init_cnt   <= init_cnt_nxt;
            upd_cnt    <= upd_cnt_nxt;
            lp_cnt     <= lp_cnt_nxt;
            init_prev  <= dfi_init_start;
        end
    end

    always_comb begin
        init_nxt     = init_state;
        init_cnt_nxt = init_cnt;
        case (init_state)
            INIT_IDLE: begin
                if (init_rise) begin
                    init_cnt_nxt = '0;
                    init_nxt     = (C_INIT_CYCLES > 1) ? INIT_RUN : INIT_DONE;
                end
            end
            INIT_RUN: begin
                if (!dfi_init_start)
                    init_nxt = INIT_IDLE;
                else if (init_cnt == INIT_LAST)
                    init_nxt = INIT_DONE;
                else
                    init_cnt_nxt = init_cnt + 1'b1;
            end
            INIT_DONE: begin
                if (init_rise) begin
                    init_cnt_nxt = '0;
                    init_nxt     = INIT_RUN;
                end
            end
            default: init_nxt = INIT_IDLE;
        endcase
    end

    always_comb begin
        upd_nxt     = upd_state;
        upd_cnt_nxt = upd_cnt;
        case (upd_state)
            UPD_IDLE: begin
                if (upd_start) begin
                    upd_cnt_nxt = '0;
                    upd_nxt     = (C_TCTRLUPD_ACK > 1) ? UPD_WAIT : UPD_ACK;
                end
            end
            UPD_WAIT: begin
                if (!dfi_ctrlupd_req)
                    upd_nxt = UPD_IDLE;
                else if (upd_cnt == UPD_LAST)
                    upd_nxt = UPD_ACK;
                else
                    upd_cnt_nxt = upd_cnt + 1'b1;
            end
            UPD_ACK: begin
                if (!dfi_ctrlupd_req)
                    upd_nxt = UPD_IDLE;
            end
            default: upd_nxt = UPD_IDLE;
        endcase
    end

    always_comb begin
        lp_nxt     = lp_state;
        lp_cnt_nxt = lp_cnt;
        case (lp_state)
            LP_IDLE: begin
                if (lp_start) begin
                    lp_cnt_nxt = '0;
                    lp_nxt     = (C_TLP_ACK > 1) ? LP_WAIT : LP_ACK;
                end
            end
            LP_WAIT: begin
                if (!lp_req)
                    lp_nxt = LP_IDLE;
                else if (lp_cnt == LP_LAST)
                    lp_nxt = LP_ACK;
                else
                    lp_cnt_nxt = lp_cnt + 1'b1;
            end
            LP_ACK: begin
                if (!lp_req)
                    lp_nxt = LP_IDLE;
            end
            default: lp_nxt = LP_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < C_TPHY_RDLAT; i++)
                rd_dly[i] <= '0;
            beat_cnt <= '0;
        end else begin
            rd_dly[0] <= init_complete ? dfi_rddata_en : '0;
            for (int i = 1; i < C_TPHY_RDLAT; i++)
                rd_dly[i] <= rd_dly[i-1];
            if (|dfi_rddata_valid)
                beat_cnt <= beat_cnt + 32'(C_DFI_FREQ_RATIO);
        end
    end

    always_comb begin
        dfi_rddata = '0;
        if (|dfi_rddata_valid) begin
            for (int p = 0; p < C_DFI_FREQ_RATIO; p++)
                dfi_rddata[p*C_DFI_DATA_WIDTH +: C_DFI_DATA_WIDTH] = C_DFI_DATA_WIDTH'(beat_cnt + 32'(p));
        end
    end

    assign dfi_rddata_valid  = rd_dly[C_TPHY_RDLAT-1];
    assign dfi_init_complete = init_complete;
    assign dfi_ctrlupd_ack   = (upd_state == UPD_ACK);
    assign dfi_lp_ack        = (lp_state == LP_ACK);
    assign dfi_phyupd_req    = 1'b0;
    assign dfi_phyupd_type   = 2'b00;

endmodule

// File: tb/tb_dfi_phy_lite_resp.sv
// Directed bench for dfi_phy_lite_resp with hand-computed expectations.
module tb_dfi_phy_lite_resp;

    localparam int RATIO = 4;
    localparam int EN_W  = 4 * RATIO;
    localparam int RD_W  = 32 * RATIO;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             dfi_init_start = 1'b0;
    logic             dfi_init_complete;
    logic             dfi_ctrlupd_req = 1'b0;
    logic             dfi_ctrlupd_ack;
    logic             dfi_phyupd_req;
    logic [1:0]       dfi_phyupd_type;
    logic             dfi_lp_ctrl_req = 1'b0;
    logic             dfi_lp_data_req = 1'b0;
    logic             dfi_lp_ack;
    logic [EN_W-1:0]  dfi_rddata_en = '0;
    logic [EN_W-1:0]  dfi_rddata_valid;
    logic [RD_W-1:0]  dfi_rddata;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    dfi_phy_lite_resp dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .dfi_init_start    (dfi_init_start),
        .dfi_init_complete (dfi_init_complete),
        .dfi_ctrlupd_req   (dfi_ctrlupd_req),
        .dfi_ctrlupd_ack   (dfi_ctrlupd_ack),
        .dfi_phyupd_req    (dfi_phyupd_req),
        .dfi_phyupd_type   (dfi_phyupd_type),
        .dfi_lp_ctrl_req   (dfi_lp_ctrl_req),
        .dfi_lp_data_req   (dfi_lp_data_req),
        .dfi_lp_ack        (dfi_lp_ack),
        .dfi_rddata_en     (dfi_rddata_en),
        .dfi_rddata_valid  (dfi_rddata_valid),
        .dfi_rddata        (dfi_rddata)
    );

    task automatic chk_eq(input string tag, input logic [RD_W-1:0] obs, input logic [RD_W-1:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h want %0h", tag, cyc, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic tick_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk_eq({tag, "_cmpl"}, RD_W'(dfi_init_complete), '0);
        chk_eq({tag, "_upd"},  RD_W'(dfi_ctrlupd_ack), '0);
        chk_eq({tag, "_lp"},   RD_W'(dfi_lp_ack), '0);
        chk_eq({tag, "_phy"},  RD_W'({dfi_phyupd_req, dfi_phyupd_type}), '0);
        chk_eq({tag, "_vld"},  RD_W'(dfi_rddata_valid), '0);
        chk_eq({tag, "_dat"},  dfi_rddata, '0);
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        chk_all_zero("rst");
        rst_n = 1'b1;
        cyc = 0;

        // Init from idle: edge at 5, complete at 21
        tick_to(5);
        dfi_init_start = 1'b1;
        tick_to(6);
        chk_eq("init_run_c6", RD_W'(dfi_init_complete), '0);
        tick_to(20);
        chk_eq("init_c20", RD_W'(dfi_init_complete), '0);
        tick_to(21);
        chk_eq("init_c21", RD_W'(dfi_init_complete), 1);
        chk_eq("init_c21_upd", RD_W'(dfi_ctrlupd_ack), '0);
        chk_eq("init_c21_vld", RD_W'(dfi_rddata_valid), '0);

        // Frequency change re-init, aborted on cycle 10 of the run, then restarted
        tick_to(22);
        dfi_init_start = 1'b0;
        tick_to(24);
        chk_eq("fc_c24", RD_W'(dfi_init_complete), 1);
        dfi_init_start = 1'b1;
        tick_to(25);
        chk_eq("fc_drop_c25", RD_W'(dfi_init_complete), '0);
        tick_to(34);
        dfi_init_start = 1'b0;
        tick_to(37);
        dfi_init_start = 1'b1;
        tick_to(40);
        chk_eq("abort_c40", RD_W'(dfi_init_complete), '0);
        tick_to(52);
        chk_eq("reinit_c52", RD_W'(dfi_init_complete), '0);
        tick_to(53);
        chk_eq("reinit_c53", RD_W'(dfi_init_complete), 1);

        // Read return: three back-to-back full enables, then a single-bit enable
        tick_to(60);
        chk_eq("hold_c60", RD_W'(dfi_init_complete), 1);
        dfi_rddata_en = '1;
        tick_to(63);
        dfi_rddata_en = '0;
        tick_to(65);
        chk_eq("rd_c65_vld", RD_W'(dfi_rddata_valid), '0);
        chk_eq("rd_c65_dat", dfi_rddata, '0);
        tick_to(66);
        chk_eq("rd_c66_vld", RD_W'(dfi_rddata_valid), RD_W'(16'hffff));
        chk_eq("rd_c66_dat", dfi_rddata, {32'd3, 32'd2, 32'd1, 32'd0});
        tick_to(67);
        chk_eq("rd_c67_vld", RD_W'(dfi_rddata_valid), RD_W'(16'hffff));
        chk_eq("rd_c67_dat", dfi_rddata, {32'd7, 32'd6, 32'd5, 32'd4});
        tick_to(68);
        chk_eq("rd_c68_vld", RD_W'(dfi_rddata_valid), RD_W'(16'hffff));
        chk_eq("rd_c68_dat", dfi_rddata, {32'd11, 32'd10, 32'd9, 32'd8});
        tick_to(69);
        chk_eq("rd_c69_vld", RD_W'(dfi_rddata_valid), '0);
        chk_eq("rd_c69_dat", dfi_rddata, '0);
        tick_to(70);
        dfi_rddata_en = 16'h0001;
        tick_to(71);
        dfi_rddata_en = '0;
        tick_to(76);
        chk_eq("rd_c76_vld", RD_W'(dfi_rddata_valid), RD_W'(16'h0001));
        chk_eq("rd_c76_dat", dfi_rddata, {32'd15, 32'd14, 32'd13, 32'd12});

        // Simultaneous ctrlupd + lp: ctrlupd first, lp after ctrlupd idles
        tick_to(80);
        dfi_ctrlupd_req = 1'b1;
        dfi_lp_ctrl_req = 1'b1;
        tick_to(81);
        chk_eq("upd_c81", RD_W'(dfi_ctrlupd_ack), '0);
        tick_to(82);
        chk_eq("upd_c82", RD_W'(dfi_ctrlupd_ack), 1);
        chk_eq("lp_c82", RD_W'(dfi_lp_ack), '0);
        tick_to(85);
        dfi_ctrlupd_req = 1'b0;
        chk_eq("upd_c85", RD_W'(dfi_ctrlupd_ack), 1);
        tick_to(86);
        chk_eq("upd_c86", RD_W'(dfi_ctrlupd_ack), '0);
        tick_to(88);
        chk_eq("lp_c88", RD_W'(dfi_lp_ack), '0);
        tick_to(89);
        chk_eq("lp_c89", RD_W'(dfi_lp_ack), 1);
        dfi_ctrlupd_req = 1'b1;
        tick_to(90);
        dfi_lp_ctrl_req = 1'b0;
        chk_eq("lp_c90", RD_W'(dfi_lp_ack), 1);
        tick_to(91);
        chk_eq("lp_c91", RD_W'(dfi_lp_ack), '0);
        tick_to(92);
        chk_eq("upd_blk_c92", RD_W'(dfi_ctrlupd_ack), '0);
        tick_to(93);
        chk_eq("upd_blk_c93", RD_W'(dfi_ctrlupd_ack), 1);
        tick_to(94);
        dfi_ctrlupd_req = 1'b0;
        tick_to(95);
        chk_eq("upd_c95", RD_W'(dfi_ctrlupd_ack), '0);

        // lp_data_req path
        tick_to(100);
        dfi_lp_data_req = 1'b1;
        tick_to(102);
        chk_eq("lpd_c102", RD_W'(dfi_lp_ack), '0);
        tick_to(103);
        chk_eq("lpd_c103", RD_W'(dfi_lp_ack), 1);
        tick_to(105);
        dfi_lp_data_req = 1'b0;
        chk_eq("lpd_c105", RD_W'(dfi_lp_ack), 1);
        tick_to(106);
        chk_eq("lpd_c106", RD_W'(dfi_lp_ack), '0);

        // One-cycle ctrlupd pulse aborts without ack
        tick_to(110);
        dfi_ctrlupd_req = 1'b1;
        tick_to(111);
        dfi_ctrlupd_req = 1'b0;
        for (int i = 111; i <= 116; i++) begin
            tick_to(i);
            chk_eq("upd_abort", RD_W'(dfi_ctrlupd_ack), '0);
        end

        // Reset mid-read with valids in flight
        tick_to(120);
        dfi_rddata_en = '1;
        tick_to(122);
        dfi_rddata_en = '0;
        tick_to(126);
        chk_eq("pre_rst_vld", RD_W'(dfi_rddata_valid), RD_W'(16'hffff));
        chk_eq("pre_rst_dat", dfi_rddata, {32'd19, 32'd18, 32'd17, 32'd16});
        #2;
        rst_n = 1'b0;
        dfi_init_start = 1'b0;
        #1;
        chk_all_zero("async_rst");
        repeat (2) tick();
        rst_n = 1'b1;
        cyc = 0;

        // After reset: no stale valids, enables and ctrlupd ignored before init
        tick_to(1);
        chk_eq("post_rst_c1_vld", RD_W'(dfi_rddata_valid), '0);
        tick_to(2);
        dfi_rddata_en = '1;
        tick_to(3);
        dfi_rddata_en = '0;
        dfi_ctrlupd_req = 1'b1;
        tick_to(6);
        chk_eq("preinit_upd_c6", RD_W'(dfi_ctrlupd_ack), '0);
        tick_to(8);
        chk_eq("preinit_upd_c8", RD_W'(dfi_ctrlupd_ack), '0);
        chk_eq("gated_c8_vld", RD_W'(dfi_rddata_valid), '0);
        dfi_ctrlupd_req = 1'b0;
        tick_to(10);
        dfi_init_start = 1'b1;
        tick_to(26);
        chk_eq("reinit2_c26", RD_W'(dfi_init_complete), 1);
        tick_to(30);
        dfi_rddata_en = '1;
        tick_to(31);
        dfi_rddata_en = '0;
        tick_to(36);
        chk_eq("restart_vld", RD_W'(dfi_rddata_valid), RD_W'(16'hffff));
        chk_eq("restart_dat", dfi_rddata, {32'd3, 32'd2, 32'd1, 32'd0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dfi_phy_lite_resp.md
Name: dfi_phy_lite_resp

Overview:
- PHY-side (slave-modport) responder for the DFI bus, used as a lightweight PHY model and loopback target for controller bring-up and simulation.
- Implements four PHY behaviours:
  - init handshake;
  - ctrlupd acknowledge;
  - low-power acknowledge;
  - read-data return with fixed tphy_rdlat latency and a deterministic data pattern.
- Sits directly below the memory controller's DFI master port.

Parameters:
C_DFI_FREQ_RATIO  4  phases per controller clock
C_DFI_DATAEN_WIDTH  4  rddata_en/valid lanes
C_DFI_DATA_WIDTH  32  rddata bits per phase
C_INIT_CYCLES  16  cycles from init_start rise to init_complete (>=1)
C_TPHY_RDLAT  6  cycles from rddata_en to rddata_valid (1..31)
C_TCTRLUPD_ACK  2  cycles from ctrlupd_req to ack (>=1)
C_TLP_ACK  3  cycles from lp request to lp_ack (>=1)

Ports:
clk  in  1  controller/DFI clock
rst_n  in  1  asynchronous active-low reset
dfi_init_start  in  1  init/frequency-change request
dfi_init_complete  out  1  PHY initialised
dfi_ctrlupd_req  in  1  controller update request
dfi_ctrlupd_ack  out  1  update acknowledge
dfi_phyupd_req  out  1  tied 0
dfi_phyupd_type  out  2  tied 0
dfi_lp_ctrl_req  in  1  low-power control request
dfi_lp_data_req  in  1  low-power data request
dfi_lp_ack  out  1  low-power acknowledge
dfi_rddata_en  in  C_DFI_DATAEN_WIDTH*C_DFI_FREQ_RATIO  read enable; bit lane*RATIO+phase
dfi_rddata_valid  out  C_DFI_DATAEN_WIDTH*C_DFI_FREQ_RATIO  delayed read enable, same layout
dfi_rddata  out  C_DFI_DATA_WIDTH*C_DFI_FREQ_RATIO  read data; phase p at [p*DW +: DW]

Behaviour:
- Reset: every output 0; all FSMs idle; counters 0; delay line cleared. Reset is asynchronous and takes effect mid-operation.
- Flat bus layout matches the DFI interface's packed [width][ratio] arrays: the phase index is the inner (least-significant) dimension.

Init FSM (INIT_IDLE, INIT_RUN, INIT_DONE):
- INIT_IDLE: on a sampled 0->1 edge of dfi_init_start, go to INIT_RUN and clear the counter.
- INIT_RUN: count C_INIT_CYCLES cycles, then go to INIT_DONE.
  - dfi_init_complete is registered and asserts exactly C_INIT_CYCLES cycles after the edge cycle.
  - If init_start falls during INIT_RUN, return to INIT_IDLE; no complete.
- INIT_DONE: init_complete=1.
  - A new 0->1 edge of init_start (frequency change) drops init_complete the next cycle and restarts INIT_RUN.
  - A held-high init_start does not retrigger.

Ctrlupd FSM (UPD_IDLE, UPD_WAIT, UPD_ACK):
- Entry: only when init_complete=1 and dfi_ctrlupd_req=1; requests while not initialised are ignored.
- UPD_WAIT: after C_TCTRLUPD_ACK cycles, go to UPD_ACK.
  - If req drops during UPD_WAIT, abort to UPD_IDLE with no ack.
- UPD_ACK: ack=1 while req=1. Ack drops the cycle after req falls; return to idle.

Low-power FSM (LP_IDLE, LP_WAIT, LP_ACK):
- Request = lp_ctrl_req OR lp_data_req. Same timing and abort rules as ctrlupd, using C_TLP_ACK.
- lp_ack drops the cycle after both reqs are low.
- Arbitration:
  - The LP FSM does not leave LP_IDLE while the ctrlupd FSM is non-idle.
  - On simultaneous new requests, ctrlupd is taken first and LP waits.
  - The ctrlupd FSM likewise does not leave idle while LP is non-idle.

Read path:
- A C_TPHY_RDLAT-deep shift register of the rddata_en vector.
- Sampling is gated: en bits are sampled only when init_complete=1, otherwise a zero vector is sampled.
- dfi_rddata_valid equals the gated en from exactly C_TPHY_RDLAT cycles earlier.
- Back-to-back enables produce back-to-back valids; there is no gap and no drop.
- Data pattern:
  - 32-bit beat counter, reset 0.
  - On every cycle with any valid bit set, phase p of rddata = beat_cnt+p, zero-extended or truncated to DW; the counter then advances by C_DFI_FREQ_RATIO.
  - Arithmetic wraps modulo 2^32.
  - rddata is 0 in cycles with no valid bit.
- Init re-run (init_complete falling) does not flush in-flight valids already in the delay line.

Test Plan:
- Reset, pulse init_start high at cycle 5 and hold -> init_complete rises at cycle 21 (C_INIT_CYCLES=16); all other outputs remain 0.
- Drop init_start at cycle 10 of INIT_RUN, raise again 3 cycles later -> no complete from the first run; complete exactly 16 cycles after the second edge.
- After init, assert rddata_en=all-ones for 3 consecutive cycles -> valid=all-ones for 3 consecutive cycles starting 6 cycles later; rddata phases = {0,1,2,3}, {4,5,6,7}, {8,9,10,11}.
- Raise ctrlupd_req and lp_ctrl_req in the same cycle, hold both -> ctrlupd_ack after 2 cycles; drop ctrlupd_req -> ack falls next cycle; lp_ack asserts 3 cycles after the ctrlupd FSM returns idle.
- ctrlupd_req high 1 cycle only, then low -> no ack ever; ctrlupd_req before init_complete -> ignored.
- Assert rst_n low mid-read with valids in flight -> all outputs 0 asynchronously; after release no stale valid appears; beat counter restarts at 0.
